// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control sequencer:
// FSM states, opcodes, ALU/trap encodings and the decoded control vector.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_TRAP   = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_FOUR = 2'b01,
    SRCB_IMM  = 2'b10
  } srcb_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_BR    = 2'b01,
    ALU_FUNCT = 2'b10
  } aluop_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_TIMEOUT = 2'b10
  } cause_t;

  typedef struct packed {
    logic   pc_write;
    logic   ir_write;
    logic   iord;
    logic   mem_read;
    logic   mem_write;
    logic   mem_to_reg;
    logic   reg_write;
    logic   alu_src_a;
    srcb_t  alu_src_b;
    aluop_t alu_op;
    logic   pc_src;
  } ctrl_t;

  // States that own the memory port and can stall on mem_ready.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational state -> control-vector decode. FETCH and BRANCH also
// look at mem_ready / zero to qualify the IR and PC load strobes.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  input  logic   zero,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: ctrl.alu_src_b = SRCB_IMM;
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_EXECI: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: ctrl.reg_write = 1'b1;
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALU_BR;
        ctrl.pc_src    = 1'b1;
        ctrl.pc_write  = zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I control FSM: state register, memory-wait timeout,
// sticky trap and retired-instruction counter around mc_ctrl_outdec.
module multicycle_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             PCSrc,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instr_retired
);

  localparam int WC_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_t           state, state_nxt;
  logic [WC_W-1:0]  wait_cnt;
  logic [CNT_W-1:0] retired;
  logic             trap_q, trap_set, retire, stall_trap;
  cause_t           cause_q, cause_nxt;
  ctrl_t            ctrl;

  // mem_ready on the limit cycle still completes, so the stall check needs !mem_ready.
  assign stall_trap = (MEM_TIMEOUT != 0) && is_mem_state(state) && !mem_ready &&
                      (wait_cnt == WC_W'(MEM_TIMEOUT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    trap_set  = 1'b0;
    cause_nxt = CAUSE_NONE;
    retire    = 1'b0;
    case (state)
      S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_RTYPE:          state_nxt = S_EXEC;
          OP_ITYPE:          state_nxt = S_EXECI;
          OP_BRANCH:         state_nxt = S_BRANCH;
          default: begin
            state_nxt = S_TRAP;
            trap_set  = 1'b1;
            cause_nxt = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: state_nxt = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_nxt = S_MEMWB;
      S_MEMWR: begin
        if (mem_ready) begin
          state_nxt = S_FETCH;
          retire    = 1'b1;
        end
      end
      S_EXEC, S_EXECI: state_nxt = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH: begin
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      S_TRAP:  state_nxt = S_TRAP;
      default: state_nxt = S_FETCH;
    endcase
    if (stall_trap) begin
      state_nxt = S_TRAP;
      trap_set  = 1'b1;
      cause_nxt = CAUSE_TIMEOUT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      retired  <= '0;
      trap_q   <= 1'b0;
      cause_q  <= CAUSE_NONE;
    end else begin
      // Any state change is an entry into the next state, so the wait count restarts.
      if (state_nxt != state)
        wait_cnt <= '0;
      else if (is_mem_state(state) && !mem_ready && (wait_cnt != '1))
        wait_cnt <= wait_cnt + WC_W'(1);
      if (retire)
        retired <= retired + CNT_W'(1);
      if (trap_set) begin
        trap_q  <= 1'b1;
        cause_q <= cause_nxt;
      end
    end
  end

  mc_ctrl_outdec u_outdec (
    .state     (state),
    .mem_ready (mem_ready),
    .zero      (zero),
    .ctrl      (ctrl)
  );

  // Reset blanks every output combinationally, e.g. drops MemWrite mid-store.
  assign PCWrite       = !reset && ctrl.pc_write;
  assign IRWrite       = !reset && ctrl.ir_write;
  assign IorD          = !reset && ctrl.iord;
  assign MemRead       = !reset && ctrl.mem_read;
  assign MemWrite      = !reset && ctrl.mem_write;
  assign MemtoReg      = !reset && ctrl.mem_to_reg;
  assign RegWrite      = !reset && ctrl.reg_write;
  assign ALUSrcA       = !reset && ctrl.alu_src_a;
  assign ALUSrcB       = reset ? 2'b00 : ctrl.alu_src_b;
  assign ALUOp         = reset ? 2'b00 : ctrl.alu_op;
  assign PCSrc         = !reset && ctrl.pc_src;
  assign trap          = !reset && trap_q;
  assign trap_cause    = reset ? 2'b00 : cause_q;
  assign instr_retired = reset ? '0 : retired;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: per-instruction cycle tables built from the
// CPI/output rules, directed corner cases, and randomized instruction streams.
module tb_multicycle_ctrl_fsm;

  logic        clk = 1'b0, reset = 1'b1;
  logic [6:0]  opcode = '0;
  logic        zero = 1'b0, mem_ready = 1'b0;
  logic        PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegWrite, ALUSrcA, PCSrc, trap;
  logic [1:0]  ALUSrcB, ALUOp, trap_cause;
  logic [31:0] instr_retired;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .trap(trap),
    .trap_cause(trap_cause), .instr_retired(instr_retired)
  );

  wire [15:0] outv = {PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegWrite,
                      ALUSrcA, ALUSrcB, ALUOp, PCSrc, trap, trap_cause};

  typedef struct {
    logic        mr;
    logic        z;
    logic [6:0]  op;
    logic [15:0] vec;
    int unsigned ret;
  } rec_t;

  rec_t        tbl[$];
  int          n_cmp = 0, n_bad = 0;
  int unsigned model_ret = 0;

  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BR = 7'b1100011;

  function automatic logic [15:0] mk(input logic pcw, irw, iord, mr, mw, mtr, rw, a,
                                     input logic [1:0] b, op, input logic pcs, tr,
                                     input logic [1:0] c);
    return {pcw, irw, iord, mr, mw, mtr, rw, a, b, op, pcs, tr, c};
  endfunction

  // Expected control vectors, one per step of an instruction's life.
  function automatic logic [15:0] v_fetch(input logic r);
    return mk(r, r, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 2'b00);
  endfunction
  function automatic logic [15:0] v_decode();  return mk(0,0,0,0,0,0,0,0,2'b10,2'b00,0,0,2'b00); endfunction
  function automatic logic [15:0] v_memadr();  return mk(0,0,0,0,0,0,0,1,2'b10,2'b00,0,0,2'b00); endfunction
  function automatic logic [15:0] v_memrd();   return mk(0,0,1,1,0,0,0,0,2'b00,2'b00,0,0,2'b00); endfunction
  function automatic logic [15:0] v_memwb();   return mk(0,0,0,0,0,1,1,0,2'b00,2'b00,0,0,2'b00); endfunction
  function automatic logic [15:0] v_memwr();   return mk(0,0,1,0,1,0,0,0,2'b00,2'b00,0,0,2'b00); endfunction
  function automatic logic [15:0] v_exec();    return mk(0,0,0,0,0,0,0,1,2'b00,2'b10,0,0,2'b00); endfunction
  function automatic logic [15:0] v_execi();   return mk(0,0,0,0,0,0,0,1,2'b10,2'b10,0,0,2'b00); endfunction
  function automatic logic [15:0] v_aluwb();   return mk(0,0,0,0,0,0,1,0,2'b00,2'b00,0,0,2'b00); endfunction
  function automatic logic [15:0] v_branch(input logic z);
    return mk(z, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 1, 0, 2'b00);
  endfunction
  function automatic logic [15:0] v_trap(input logic [1:0] c);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, c);
  endfunction

  task automatic push(input logic mr, input logic z, input logic [6:0] op, input logic [15:0] v);
    rec_t r;
    r.mr = mr; r.z = z; r.op = op; r.vec = v; r.ret = model_ret;
    tbl.push_back(r);
  endtask

  task automatic trap_push(input int n, input logic [1:0] c, input logic [6:0] op);
    for (int i = 0; i < n; i++) push(1'($urandom), 1'($urandom), op, v_trap(c));
  endtask

  // A memory-owning step: w stall cycles, then completion; 16+ stalls end in a timeout trap.
  task automatic mem_phase(input int w, input logic [15:0] wait_v, input logic [15:0] done_v,
                           input logic z, input logic [6:0] op, output bit trapped);
    int nw;
    nw = (w >= 16) ? 16 : w;
    for (int i = 0; i < nw; i++) push(1'b0, z, op, wait_v);
    trapped = (w >= 16);
    if (trapped) trap_push(3, 2'b10, op);
    else         push(1'b1, z, op, done_v);
  endtask

  task automatic add_instr(input logic [6:0] op, input int fw, input int mw, input logic z,
                           output bit trapped);
    mem_phase(fw, v_fetch(1'b0), v_fetch(1'b1), z, op, trapped);
    if (trapped) return;
    push(1'($urandom), z, op, v_decode());
    case (op)
      LD: begin
        push(1'($urandom), z, op, v_memadr());
        mem_phase(mw, v_memrd(), v_memrd(), z, op, trapped);
        if (!trapped) begin
          push(1'($urandom), z, op, v_memwb());
          model_ret++;
        end
      end
      ST: begin
        push(1'($urandom), z, op, v_memadr());
        mem_phase(mw, v_memwr(), v_memwr(), z, op, trapped);
        if (!trapped) model_ret++;
      end
      RT: begin
        push(1'($urandom), z, op, v_exec());
        push(1'($urandom), z, op, v_aluwb());
        model_ret++;
      end
      IT: begin
        push(1'($urandom), z, op, v_execi());
        push(1'($urandom), z, op, v_aluwb());
        model_ret++;
      end
      BR: begin
        push(1'($urandom), z, op, v_branch(z));
        model_ret++;
      end
      default: begin
        trap_push(3, 2'b01, op);
        trapped = 1'b1;
      end
    endcase
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, got, exp);
    end
  endtask

  // Entered and left just after a rising edge.
  task automatic run_tbl(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      mem_ready = tbl[i].mr;
      zero      = tbl[i].z;
      opcode    = tbl[i].op;
      @(negedge clk);
      check({name, ".ctrl"}, i, {16'h0, outv}, {16'h0, tbl[i].vec});
      check({name, ".retired"}, i, instr_retired, tbl[i].ret);
      @(posedge clk);
      #1;
    end
    tbl.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    check("reset.outs", 0, {16'h0, outv}, 32'h0);
    check("reset.retired", 0, instr_retired, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_ret = 0;
  endtask

  initial begin
    bit tr;
    logic [6:0] op;
    int sel;

    do_reset();

    // R-type, I-type, load with 3 MEMRD stalls, both branch outcomes, store.
    add_instr(RT, 0, 0, 1'b0, tr);
    add_instr(IT, 0, 0, 1'b1, tr);
    add_instr(LD, 0, 3, 1'b0, tr);
    add_instr(BR, 0, 0, 1'b1, tr);
    add_instr(BR, 0, 0, 1'b0, tr);
    add_instr(ST, 2, 1, 1'b0, tr);
    run_tbl("basic");

    // Illegal opcode: trap held 20 cycles, count frozen.
    add_instr(7'b1111111, 0, 0, 1'b0, tr);
    trap_push(17, 2'b01, 7'b1111111);
    run_tbl("illegal");
    do_reset();

    // Store times out on the 16th stall cycle.
    add_instr(RT, 0, 0, 1'b0, tr);
    add_instr(ST, 0, 16, 1'b0, tr);
    trap_push(5, 2'b10, ST);
    run_tbl("timeout");
    do_reset();

    // mem_ready arriving on the limit cycle completes normally.
    add_instr(ST, 0, 15, 1'b0, tr);
    add_instr(RT, 15, 0, 1'b0, tr);
    run_tbl("limit_ok");
    do_reset();

    // Reset asserted in the middle of a stalled store.
    add_instr(RT, 0, 0, 1'b0, tr);
    push(1'b1, 1'b0, ST, v_fetch(1'b1));
    push(1'b0, 1'b0, ST, v_decode());
    push(1'b0, 1'b0, ST, v_memadr());
    push(1'b0, 1'b0, ST, v_memwr());
    run_tbl("pre_rst");
    mem_ready = 1'b0;
    #1;
    check("memwr.MemWrite", 0, {31'h0, MemWrite}, 32'h1);
    check("memwr.retired", 0, instr_retired, 32'h1);
    reset = 1'b1;
    #1;
    check("rst_memwr.MemWrite", 0, {31'h0, MemWrite}, 32'h0);
    check("rst_memwr.outs", 0, {16'h0, outv}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_ret = 0;
    add_instr(BR, 1, 0, 1'b1, tr);
    run_tbl("post_rst");
    do_reset();

    // Random instruction stream against the table model.
    for (int k = 0; k < 150; k++) begin
      sel = $urandom_range(0, 11);
      case (sel)
        0, 1:    op = LD;
        2, 3:    op = ST;
        4, 5:    op = RT;
        6, 7:    op = IT;
        8, 9:    op = BR;
        10: begin
          op = 7'($urandom);
          if (op == LD || op == ST || op == RT || op == IT || op == BR) op = 7'b1111111;
        end
        default: op = RT;
      endcase
      add_instr(op,
                ($urandom_range(0, 19) == 0) ? $urandom_range(14, 18) : $urandom_range(0, 2),
                ($urandom_range(0, 9) == 0)  ? $urandom_range(14, 18) : $urandom_range(0, 3),
                1'($urandom), tr);
      run_tbl("rand");
      if (tr) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
